fence_ctrl: RTL and testbench



---
 rtl/fence_ctrl_pkg.sv | 20 ++
 rtl/fence_ctrl.sv | 152 +++++++++++++++
 tb/tb_fence_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fence_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fence_ctrl_pkg
// Shared definitions for the FENCE / FENCE.I sequencer in the issue stage.
//   fc_state_e : sequencer state encodings
//   FC_CNT_W   : width of the drain-idle counter (holds up to 15)
// -----------------------------------------------------------------------------
package fence_ctrl_pkg;

    localparam int FC_CNT_W = 4;

    typedef enum logic [2:0] {
        FC_IDLE  = 3'd0,
        FC_DRAIN = 3'd1,
        FC_DMFL  = 3'd2,
        FC_IMINV = 3'd3,
        FC_REDIR = 3'd4,
        FC_DONE  = 3'd5
    } fc_state_e;

endpackage

// File: rtl/fence_ctrl.sv
// -----------------------------------------------------------------------------
// fence_ctrl
// Sequencer for FENCE and FENCE.I held in the issue stage. Every fence waits
// for the integer and load/store pipes to stay idle for DRAIN_HOLD consecutive
// cycles. FENCE.I then writes back the D-cache, invalidates the I-cache and
// redirects fetch to pc+4. The issue stage retires the fence on req_done.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   pipe_flush               pipeline abort
//   req_valid/_fencei/_pc    fence request from issue (level, held to done)
//   req_done                 one-cycle completion pulse
//   ip_busy, lsp_busy        pipe occupancy
//   dm_flush_req/_resp       D-cache writeback-all handshake (level / pulse)
//   im_invalidate_req/_resp  I-cache invalidate-all handshake (level / pulse)
//   ix_if_pc_override        one-cycle fetch redirect pulse
//   ix_if_new_pc             redirect target (pc+4)
//   busy                     sequencer not idle
//   fence_count              completed fences, wrapping
//
// All outputs are decoded from registers only; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module fence_ctrl
    import fence_ctrl_pkg::*;
#(
    parameter int DRAIN_HOLD = 1,   // 1..15
    parameter int XLEN       = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_flush,
    input  logic            req_valid,
    input  logic            req_fencei,
    input  logic [XLEN-1:0] req_pc,
    output logic            req_done,
    input  logic            ip_busy,
    input  logic            lsp_busy,
    output logic            dm_flush_req,
    input  logic            dm_flush_resp,
    output logic            im_invalidate_req,
    input  logic            im_invalidate_resp,
    output logic            ix_if_pc_override,
    output logic [XLEN-1:0] ix_if_new_pc,
    output logic            busy,
    output logic [31:0]     fence_count
);

    localparam logic [FC_CNT_W-1:0] HOLD_CNT = FC_CNT_W'(DRAIN_HOLD);

    fc_state_e             state_q, state_d;
    logic [FC_CNT_W-1:0]   cnt_q, cnt_d;
    logic                  fencei_q, fencei_d;
    logic                  aborted_q, aborted_d;
    logic [XLEN-1:0]       npc_q, npc_d;
    logic [31:0]           count_q, count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FC_IDLE;
            cnt_q     <= '0;
            fencei_q  <= 1'b0;
            aborted_q <= 1'b0;
            npc_q     <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fencei_q  <= fencei_d;
            aborted_q <= aborted_d;
            npc_q     <= npc_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fencei_d  = fencei_q;
        aborted_d = aborted_q;
        npc_d     = npc_q;
        count_d   = count_q;

        case (state_q)
            FC_IDLE: begin
                // An abort in the same cycle wins over a new request.
                if (req_valid && !pipe_flush) begin
                    fencei_d  = req_fencei;
                    npc_d     = req_pc + XLEN'(4);  // wraps modulo 2^XLEN
                    cnt_d     = '0;
                    aborted_d = 1'b0;
                    state_d   = FC_DRAIN;
                end
            end

            FC_DRAIN: begin
                if (pipe_flush) begin
                    state_d = FC_IDLE;
                end else begin
                    if (ip_busy || lsp_busy) begin
                        cnt_d = '0;
                    end else if (cnt_q != HOLD_CNT) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    // Looking at the updated count lets the last idle cycle
                    // leave DRAIN, so the minimum stay is DRAIN_HOLD cycles.
                    if (cnt_d == HOLD_CNT) begin
                        state_d = fencei_q ? FC_DMFL : FC_DONE;
                    end
                end
            end

            FC_DMFL: begin
                // A cache handshake in flight is never abandoned; the abort
                // only decides where we go once it finishes.
                if (pipe_flush) begin
                    aborted_d = 1'b1;
                end
                if (dm_flush_resp) begin
                    state_d = (aborted_q || pipe_flush) ? FC_IDLE : FC_IMINV;
                end
            end

            FC_IMINV: begin
                if (pipe_flush) begin
                    aborted_d = 1'b1;
                end
                if (im_invalidate_resp) begin
                    state_d = (aborted_q || pipe_flush) ? FC_IDLE : FC_REDIR;
                end
            end

            FC_REDIR, FC_DONE: begin
                count_d = count_q + 32'd1;
                state_d = FC_IDLE;
            end

            default: begin
                state_d = FC_IDLE;
            end
        endcase
    end

    assign req_done          = (state_q == FC_REDIR) || (state_q == FC_DONE);
    assign ix_if_pc_override = (state_q == FC_REDIR);
    assign ix_if_new_pc      = npc_q;
    assign dm_flush_req      = (state_q == FC_DMFL);
    assign im_invalidate_req = (state_q == FC_IMINV);
    assign busy              = (state_q != FC_IDLE);
    assign fence_count       = count_q;

endmodule

// File: tb/tb_fence_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fence_ctrl
// Two instances: u_dut1 (DRAIN_HOLD=1) runs a per-cycle vector table; u_dut3
// (DRAIN_HOLD=3) runs a hand-written drain sequence. Each vector's inputs are
// applied at the falling edge and the registered outputs are compared just
// after the following rising edge.
// -----------------------------------------------------------------------------
module tb_fence_ctrl;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            pipe_flush;
    logic            req_valid;
    logic            req_fencei;
    logic [XLEN-1:0] req_pc;
    logic            ip_busy;
    logic            lsp_busy;
    logic            dm_resp;
    logic            im_resp;

    logic            done1, dm1, im1, ovr1, busy1;
    logic [XLEN-1:0] npc1;
    logic [31:0]     cnt1;

    logic            req_valid3, ip_busy3, lsp_busy3;
    logic            done3, dm3, im3, ovr3, busy3;
    logic [XLEN-1:0] npc3;
    logic [31:0]     cnt3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fence_ctrl #(.DRAIN_HOLD(1), .XLEN(XLEN)) u_dut1 (
        .clk                (clk),
        .rst                (rst),
        .pipe_flush         (pipe_flush),
        .req_valid          (req_valid),
        .req_fencei         (req_fencei),
        .req_pc             (req_pc),
        .req_done           (done1),
        .ip_busy            (ip_busy),
        .lsp_busy           (lsp_busy),
        .dm_flush_req       (dm1),
        .dm_flush_resp      (dm_resp),
        .im_invalidate_req  (im1),
        .im_invalidate_resp (im_resp),
        .ix_if_pc_override  (ovr1),
        .ix_if_new_pc       (npc1),
        .busy               (busy1),
        .fence_count        (cnt1)
    );

    fence_ctrl #(.DRAIN_HOLD(3), .XLEN(XLEN)) u_dut3 (
        .clk                (clk),
        .rst                (rst),
        .pipe_flush         (pipe_flush),
        .req_valid          (req_valid3),
        .req_fencei         (req_fencei),
        .req_pc             (req_pc),
        .req_done           (done3),
        .ip_busy            (ip_busy3),
        .lsp_busy           (lsp_busy3),
        .dm_flush_req       (dm3),
        .dm_flush_resp      (dm_resp),
        .im_invalidate_req  (im3),
        .im_invalidate_resp (im_resp),
        .ix_if_pc_override  (ovr3),
        .ix_if_new_pc       (npc3),
        .busy               (busy3),
        .fence_count        (cnt3)
    );

    typedef struct {
        logic            rst, rv, fi, pf, ib, dr, ir;
        logic [XLEN-1:0] pc;
        logic            e_done, e_dm, e_im, e_ovr, e_busy;
        logic [31:0]     e_cnt;
        logic [XLEN-1:0] e_npc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic rv, logic fi, logic pf, logic ib,
                                logic dr, logic ir, logic [XLEN-1:0] pc,
                                logic done, logic dm, logic im, logic ovr,
                                logic bsy, logic [31:0] cnt, logic [XLEN-1:0] npc);
        vec_t v;
        v.rst = r;  v.rv = rv; v.fi = fi; v.pf = pf; v.ib = ib; v.dr = dr; v.ir = ir;
        v.pc = pc;
        v.e_done = done; v.e_dm = dm; v.e_im = im; v.e_ovr = ovr; v.e_busy = bsy;
        v.e_cnt = cnt; v.e_npc = npc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pat_ip[7];
        int pat_ls[7];

        // ---------------- vector table (u_dut1, DRAIN_HOLD=1) ----------------
        //                 rst rv fi pf ib dr ir  pc                      done dm im ovr bsy cnt npc
        // Plain FENCE, ip_busy high for 3 cycles after accept
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 64'h0,                  0, 0, 0, 0, 1, 0, 64'h0));
        vq.push_back(mk(0, 1, 0, 0, 1, 0, 0, 64'h0,                  0, 0, 0, 0, 1, 0, 64'h0));
        vq.push_back(mk(0, 1, 0, 0, 1, 0, 0, 64'h0,                  0, 0, 0, 0, 1, 0, 64'h0));
        vq.push_back(mk(0, 1, 0, 0, 1, 0, 0, 64'h0,                  0, 0, 0, 0, 1, 0, 64'h0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 64'h0,                  1, 0, 0, 0, 1, 0, 64'h0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 64'h0,                  0, 0, 0, 0, 0, 1, 64'h0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 64'h0,                  0, 0, 0, 0, 0, 1, 64'h0));
        // FENCE.I at 0x8000_0010, dm resp on 5th cycle, im resp on 2nd
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 64'h8000_0010,          0, 0, 0, 0, 1, 1, 64'h0));
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 64'h0,                  0, 1, 0, 0, 1, 1, 64'h0));
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 64'h0,                  0, 1, 0, 0, 1, 1, 64'h0));
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 64'h0,                  0, 1, 0, 0, 1, 1, 64'h0));
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 64'h0,                  0, 1, 0, 0, 1, 1, 64'h0));
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 64'h0,                  0, 1, 0, 0, 1, 1, 64'h0));
        vq.push_back(mk(0, 1, 1, 0, 0, 1, 0, 64'h0,                  0, 0, 1, 0, 1, 1, 64'h0));
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 64'h0,                  0, 0, 1, 0, 1, 1, 64'h0));
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 1, 64'h0,                  1, 0, 0, 1, 1, 1, 64'h8000_0014));
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 64'h0,                  0, 0, 0, 0, 0, 2, 64'h0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 64'h0,                  0, 0, 0, 0, 0, 2, 64'h0));
        // FENCE.I aborted during DM_FLUSH
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 64'h1000,               0, 0, 0, 0, 1, 2, 64'h0));
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 64'h0,                  0, 1, 0, 0, 1, 2, 64'h0));
        vq.push_back(mk(0, 0, 1, 1, 0, 0, 0, 64'h0,                  0, 1, 0, 0, 1, 2, 64'h0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 64'h0,                  0, 1, 0, 0, 1, 2, 64'h0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 64'h0,                  0, 0, 0, 0, 0, 2, 64'h0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 64'h0,                  0, 0, 0, 0, 0, 2, 64'h0));
        // Abort in DRAIN, then FENCE.I at the top of memory (target wraps)
        vq.push_back(mk(0, 1, 1, 0, 1, 0, 0, 64'h2000,               0, 0, 0, 0, 1, 2, 64'h0));
        vq.push_back(mk(0, 1, 1, 1, 1, 0, 0, 64'h2000,               0, 0, 0, 0, 0, 2, 64'h0));
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 1, 2, 64'h0));
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 64'h0,                  0, 1, 0, 0, 1, 2, 64'h0));
        vq.push_back(mk(0, 1, 1, 0, 0, 1, 0, 64'h0,                  0, 0, 1, 0, 1, 2, 64'h0));
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 1, 64'h0,                  1, 0, 0, 1, 1, 2, 64'h0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 64'h0,                  0, 0, 0, 0, 0, 3, 64'h0));
        // Back-to-back plain FENCEs with req_valid held high
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 64'h0,                  0, 0, 0, 0, 1, 3, 64'h0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 64'h0,                  1, 0, 0, 0, 1, 3, 64'h0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 64'h0,                  0, 0, 0, 0, 0, 4, 64'h0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 64'h0,                  0, 0, 0, 0, 1, 4, 64'h0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 64'h0,                  1, 0, 0, 0, 1, 4, 64'h0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 64'h0,                  0, 0, 0, 0, 0, 5, 64'h0));
        // Reset while in IM_INV; late responses ignored
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 64'h3000,               0, 0, 0, 0, 1, 5, 64'h0));
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 64'h0,                  0, 1, 0, 0, 1, 5, 64'h0));
        vq.push_back(mk(0, 1, 1, 0, 0, 1, 0, 64'h0,                  0, 0, 1, 0, 1, 5, 64'h0));
        vq.push_back(mk(1, 1, 1, 0, 0, 0, 0, 64'h0,                  0, 0, 0, 0, 0, 0, 64'h0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 64'h0,                  0, 0, 0, 0, 0, 0, 64'h0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 64'h0,                  0, 0, 0, 0, 0, 0, 64'h0));

        // ---------------- reset ----------------
        rst = 1'b1; pipe_flush = 1'b0; req_valid = 1'b0; req_fencei = 1'b0;
        req_pc = '0; ip_busy = 1'b0; lsp_busy = 1'b0; dm_resp = 1'b0; im_resp = 1'b0;
        req_valid3 = 1'b0; ip_busy3 = 1'b0; lsp_busy3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.done1", {63'd0, done1}, 64'd0);
        chk("rst.dm1",   {63'd0, dm1},   64'd0);
        chk("rst.im1",   {63'd0, im1},   64'd0);
        chk("rst.ovr1",  {63'd0, ovr1},  64'd0);
        chk("rst.npc1",  npc1,           64'd0);
        chk("rst.busy1", {63'd0, busy1}, 64'd0);
        chk("rst.cnt1",  {32'd0, cnt1},  64'd0);
        chk("rst.busy3", {63'd0, busy3}, 64'd0);
        chk("rst.cnt3",  {32'd0, cnt3},  64'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table-driven run ----------------
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst        = vq[i].rst;
            req_valid  = vq[i].rv;
            req_fencei = vq[i].fi;
            pipe_flush = vq[i].pf;
            ip_busy    = vq[i].ib;
            dm_resp    = vq[i].dr;
            im_resp    = vq[i].ir;
            req_pc     = vq[i].pc;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.done", i), {63'd0, done1}, {63'd0, vq[i].e_done});
            chk($sformatf("v%0d.dm", i),   {63'd0, dm1},   {63'd0, vq[i].e_dm});
            chk($sformatf("v%0d.im", i),   {63'd0, im1},   {63'd0, vq[i].e_im});
            chk($sformatf("v%0d.ovr", i),  {63'd0, ovr1},  {63'd0, vq[i].e_ovr});
            chk($sformatf("v%0d.busy", i), {63'd0, busy1}, {63'd0, vq[i].e_busy});
            chk($sformatf("v%0d.cnt", i),  {32'd0, cnt1},  {32'd0, vq[i].e_cnt});
            chk($sformatf("v%0d.both_req", i), {63'd0, dm1 & im1}, 64'd0);
            if (vq[i].e_ovr) begin
                chk($sformatf("v%0d.npc", i), npc1, vq[i].e_npc);
            end
        end

        // ---------------- u_dut3: DRAIN_HOLD=3 ----------------
        // Spurious D-cache response while idle
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0; pipe_flush = 1'b0;
        dm_resp = 1'b1; im_resp = 1'b0; req_valid3 = 1'b0;
        @(posedge clk);
        #1;
        chk("h3.spur.dm",   {63'd0, dm3},   64'd0);
        chk("h3.spur.busy", {63'd0, busy3}, 64'd0);
        chk("h3.spur.done", {63'd0, done3}, 64'd0);

        // Accept a plain FENCE
        @(negedge clk);
        dm_resp = 1'b0; req_valid3 = 1'b1; req_fencei = 1'b0;
        ip_busy3 = 1'b0; lsp_busy3 = 1'b0;
        @(posedge clk);
        #1;
        chk("h3.acc.busy", {63'd0, busy3}, 64'd1);

        // Busy pattern 1,0,0,1,0,0,0 (first from the integer pipe, second from LS)
        pat_ip = '{1, 0, 0, 0, 0, 0, 0};
        pat_ls = '{0, 0, 0, 1, 0, 0, 0};
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            ip_busy3  = (pat_ip[k] != 0);
            lsp_busy3 = (pat_ls[k] != 0);
            @(posedge clk);
            #1;
            chk($sformatf("h3.drain%0d.done", k), {63'd0, done3}, (k == 6) ? 64'd1 : 64'd0);
            chk($sformatf("h3.drain%0d.dm", k),   {63'd0, dm3},   64'd0);
        end

        @(negedge clk);
        req_valid3 = 1'b0; ip_busy3 = 1'b0; lsp_busy3 = 1'b0;
        @(posedge clk);
        #1;
        chk("h3.end.done", {63'd0, done3}, 64'd0);
        chk("h3.end.busy", {63'd0, busy3}, 64'd0);
        chk("h3.end.cnt",  {32'd0, cnt3},  64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
